// File: rtl/rr_arbiter4_pkg.sv
// rtl/rr_arbiter4_pkg.sv - shared sizes, FSM state type and one-hot helper for rr_arbiter4
package rr_arbiter4_pkg;

    localparam int NUM_REQ = 4;
    localparam int ID_W    = 2;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    function automatic logic [NUM_REQ-1:0] id_to_onehot(input logic [ID_W-1:0] id);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << id;
    endfunction

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - rotated descending priority search starting at (ptr-1) mod 4
module rr_pick4
    import rr_arbiter4_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [ID_W-1:0]    win_id,
    output logic               any
);

    logic [ID_W-1:0] idx;

    // Walk from lowest to highest priority so the nearest candidate to ptr-1 wins.
    always_comb begin
        win_id = '0;
        idx    = '0;
        any    = |req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = ptr - ID_W'(k);
            if (req[idx]) begin
                win_id = idx;
            end
        end
        win = any ? id_to_onehot(win_id) : '0;
    end

endmodule

// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - 4-way round-robin arbiter with held grants; RR_ARBITER4_TIMEOUT_EN adds forced release
module rr_arbiter4
    import rr_arbiter4_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               gnt_valid,
    output logic               timeout
);

    if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
        $error("rr_arbiter4: MAX_HOLD must be within 2..256");
    end

    state_t             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [ID_W-1:0]    gnt_id_q, gnt_id_d;

    logic [NUM_REQ-1:0] pick_win;
    logic [ID_W-1:0]    pick_id;
    logic               pick_any;

    rr_pick4 u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .win    (pick_win),
        .win_id (pick_id),
        .any    (pick_any)
    );

`ifdef RR_ARBITER4_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD);
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              timeout_q, timeout_d;
`endif

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
`ifdef RR_ARBITER4_TIMEOUT_EN
        hold_d    = hold_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d  = GRANT;
                    gnt_d    = pick_win;
                    gnt_id_d = pick_id;
`ifdef RR_ARBITER4_TIMEOUT_EN
                    hold_d   = '0;
`endif
                end
            end
            GRANT: begin
                // Releasing requester becomes ptr so it is searched last next time.
                if (!req[gnt_id_q]) begin
                    state_d  = IDLE;
                    gnt_d    = '0;
                    gnt_id_d = '0;
                    ptr_d    = gnt_id_q;
                end
`ifdef RR_ARBITER4_TIMEOUT_EN
                else if (hold_q == HOLD_W'(MAX_HOLD - 1)) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    ptr_d     = gnt_id_q;
                    timeout_d = 1'b1;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
`endif
            end
            default: begin
                state_d  = IDLE;
                gnt_d    = '0;
                gnt_id_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
`ifdef RR_ARBITER4_TIMEOUT_EN
            hold_q    <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
`ifdef RR_ARBITER4_TIMEOUT_EN
            hold_q    <= hold_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_valid = |gnt_q;
`ifdef RR_ARBITER4_TIMEOUT_EN
    assign timeout   = timeout_q;
`else
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - directed and randomised checks of rr_arbiter4 against a behavioural model
module tb_rr_arbiter4;

    localparam int MAXH = 4;
`ifdef RR_ARBITER4_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       gnt_valid;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    // Behavioural model: who holds the resource, for how long, and who was last released.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_held;
    bit m_to;

    rr_arbiter4 #(.MAX_HOLD(MAXH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .gnt       (gnt),
        .gnt_id    (gnt_id),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    always #5 clk = ~clk;

    task automatic model_step(input logic [3:0] r);
        if (!rst_n) begin
            m_busy = 0; m_owner = 0; m_ptr = 0; m_held = 0; m_to = 0;
        end else if (!m_busy) begin
            m_to = 0;
            if (r != 4'b0000) begin
                for (int k = 1; k <= 4; k++) begin
                    int c;
                    c = (m_ptr - k + 8) % 4;
                    if (r[c]) begin
                        m_owner = c;
                        break;
                    end
                end
                m_busy = 1;
                m_held = 1;
            end
        end else if (!r[m_owner]) begin
            m_busy = 0; m_ptr = m_owner; m_to = 0;
        end else if (TO_EN && m_held == MAXH) begin
            m_busy = 0; m_ptr = m_owner; m_to = 1;
        end else begin
            m_held++;
            m_to = 0;
        end
    endtask

    task automatic cyc(input logic [3:0] r);
        req = r;
        @(posedge clk);
        model_step(r);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(4'b0000);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc(4'b1111);
        cyc(4'b1111);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got=%b want=0000", gnt); end
        checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL reset_gnt_id got=%0d want=0", gnt_id); end
        checks++; if (gnt_valid !== 1'b0) begin errors++; $display("FAIL reset_gnt_valid got=%b want=0", gnt_valid); end
        checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b want=0", timeout); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        do_reset();
        cyc(4'b1111);
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL basic_first_gnt got=%b want=1000", gnt); end
        checks++; if (gnt_id !== 2'd3) begin errors++; $display("FAIL basic_first_id got=%0d want=3", gnt_id); end
        checks++; if (gnt_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got=%b want=1", gnt_valid); end
        cyc(4'b0111);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL basic_gap got=%b want=0000", gnt); end
        cyc(4'b0111);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL basic_second_gnt got=%b want=0100", gnt); end
        checks++; if (gnt_id !== 2'd2) begin errors++; $display("FAIL basic_second_id got=%0d want=2", gnt_id); end
        cyc(4'b0000);
        cyc(4'b0000);
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL basic_idle got=%b want=0000", gnt); end
    endtask

    task automatic test_ptr2();
        do_reset();
        cyc(4'b0100);
        cyc(4'b0000);
        cyc(4'b0101);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL ptr2_gnt got=%b want=0001", gnt); end
        checks++; if (gnt_id !== 2'd0) begin errors++; $display("FAIL ptr2_id got=%0d want=0", gnt_id); end
        cyc(4'b0000);
    endtask

    task automatic test_rotation();
        int order[5] = '{3, 2, 1, 0, 3};
        do_reset();
        foreach (order[i]) begin
            logic [3:0] w;
            w = 4'b0001 << order[i];
            cyc(4'b1111);
            checks++; if (gnt !== w) begin errors++; $display("FAIL rot_grant[%0d] got=%b want=%b", i, gnt, w); end
            cyc(4'b1111);
            checks++; if (gnt !== w) begin errors++; $display("FAIL rot_hold[%0d] got=%b want=%b", i, gnt, w); end
            cyc(4'b1111 & ~w);
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rot_gap[%0d] got=%b want=0000", i, gnt); end
        end
    endtask

    task automatic test_timeout();
        do_reset();
`ifdef RR_ARBITER4_TIMEOUT_EN
        for (int i = 0; i < MAXH; i++) begin
            cyc(4'b0010);
            checks++; if (gnt !== 4'b0010 || timeout !== 1'b0) begin errors++; $display("FAIL to_hold[%0d] gnt=%b timeout=%b want gnt=0010 timeout=0", i, gnt, timeout); end
        end
        cyc(4'b0010);
        checks++; if (gnt !== 4'b0000 || timeout !== 1'b1) begin errors++; $display("FAIL to_drop gnt=%b timeout=%b want gnt=0000 timeout=1", gnt, timeout); end
        cyc(4'b0010);
        checks++; if (gnt !== 4'b0010 || timeout !== 1'b0) begin errors++; $display("FAIL to_regrant gnt=%b timeout=%b want gnt=0010 timeout=0", gnt, timeout); end
`else
        for (int i = 0; i < 5 * MAXH; i++) begin
            cyc(4'b0010);
            checks++; if (gnt !== 4'b0010 || timeout !== 1'b0) begin errors++; $display("FAIL nto_hold[%0d] gnt=%b timeout=%b want gnt=0010 timeout=0", i, gnt, timeout); end
        end
`endif
        cyc(4'b0000);
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        cyc(4'b0100);
        cyc(4'b0000);
        cyc(4'b0100);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rmid_setup got=%b want=0100", gnt); end
        rst_n = 1'b0;
        cyc(4'b0101);
        rst_n = 1'b1;
        checks++; if (gnt !== 4'b0000 || gnt_id !== 2'd0 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
            errors++; $display("FAIL rmid_outputs gnt=%b id=%0d valid=%b timeout=%b want all zero", gnt, gnt_id, gnt_valid, timeout);
        end
        cyc(4'b0101);
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL rmid_ptr0 got=%b want=0100", gnt); end
        cyc(4'b0000);
    endtask

    task automatic test_random();
        logic [3:0] r;
        logic [3:0] prev_gnt;
        logic [3:0] eg;
        logic [1:0] eid;
        int         wait_cnt[4];
        do_reset();
        r = 4'b0000;
        prev_gnt = 4'b0000;
        foreach (wait_cnt[i]) wait_cnt[i] = 0;
        for (int n = 0; n < 10000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(5) == 0) r[b] = ~r[b];
            end
            cyc(r);
            eg  = m_busy ? (4'b0001 << m_owner) : 4'b0000;
            eid = m_busy ? 2'(m_owner) : 2'd0;
            checks++; if (gnt !== eg) begin errors++; $display("FAIL rnd_gnt cyc=%0d got=%b want=%b", n, gnt, eg); end
            checks++; if (gnt_id !== eid) begin errors++; $display("FAIL rnd_id cyc=%0d got=%0d want=%0d", n, gnt_id, eid); end
            checks++; if (timeout !== m_to) begin errors++; $display("FAIL rnd_timeout cyc=%0d got=%b want=%b", n, timeout, m_to); end
            checks++; if ($countones(gnt) > 1) begin errors++; $display("FAIL rnd_onehot cyc=%0d got=%b want at most one bit", n, gnt); end
            checks++; if (gnt_valid !== (|gnt)) begin errors++; $display("FAIL rnd_valid cyc=%0d got=%b want=%b", n, gnt_valid, |gnt); end
            for (int i = 0; i < 4; i++) begin
                if (!r[i]) wait_cnt[i] = 0;
                else if (prev_gnt == 4'b0000 && gnt != 4'b0000) begin
                    if (gnt[i]) wait_cnt[i] = 0;
                    else wait_cnt[i]++;
                end
            end
            for (int i = 0; i < 4; i++) begin
                checks++; if (wait_cnt[i] > 3) begin errors++; $display("FAIL rnd_fair cyc=%0d req%0d waited=%0d want<=3", n, i, wait_cnt[i]); end
            end
            prev_gnt = gnt;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b0000;
        @(negedge clk);
        test_reset();
        test_basic();
        test_ptr2();
        test_rotation();
        test_timeout();
        test_reset_mid_grant();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
